// File: rtl/stage_3_leaf_search.sv
// Leaf level of the 16-ary tag-sort tree: 256 x 16-bit bitmap nodes.
// Optional STAGE3_OCCUPANCY_EN adds a live count of stored tags.
module stage_3_leaf_search #(
  parameter  int STRIDE   = 4,
  parameter  int PREFIX_W = 8,
  localparam int TAG_W    = PREFIX_W + STRIDE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [TAG_W-1:0]    incoming_tag_in,
  input  logic [PREFIX_W-1:0] matching_prefix_in,
  input  logic [PREFIX_W-1:0] bak_prefix_in,
  input  logic                bak_valid_in,
  output logic                result_valid,
  output logic [TAG_W-1:0]    result_tag,
  output logic                result_found,
  output logic                node_empty
`ifdef STAGE3_OCCUPANCY_EN
  ,
  output logic [TAG_W:0]      occupancy
`endif
);

  localparam int NODE_W = 1 << STRIDE;
  localparam int DEPTH  = 1 << PREFIX_W;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_EVAL,
    S_BAK_RD,
    S_BAK_EVAL,
    S_WR
  } state_t;

  state_t state, state_n;

  logic [PREFIX_W-1:0] sweep;
  logic [NODE_W-1:0]   mem [DEPTH];
  logic [NODE_W-1:0]   rd_data;

  logic [TAG_W-1:0]    tag_q;
  logic [PREFIX_W-1:0] pfx_q;
  logic [PREFIX_W-1:0] bak_q;
  logic                bakv_q;
  logic [1:0]          op_q;
  logic                old_q;
  logic [NODE_W-1:0]   word_q;

  logic                re, we;
  logic [PREFIX_W-1:0] raddr, waddr;
  logic [NODE_W-1:0]   wdata;
  logic                ld_cmd, ld_word;
  logic                res_set, res_found, res_empty;
  logic [TAG_W-1:0]    res_tag;

  logic                is_ins, is_del, cmd_wr;
  logic                exact;
  logic [STRIDE-1:0]   lim;
  logic [NODE_W-1:0]   mask;
  logic [STRIDE:0]     hit, bhit;
  logic [NODE_W-1:0]   onehot, new_word;
  logic                cur_bit;

  // Highest set bit of a node word as {found, index}.
  function automatic logic [STRIDE:0] top_bit(
    input logic [NODE_W-1:0] w
  );
    logic [STRIDE:0] r;
    r = '0;
    for (int i = 0; i < NODE_W; i++)
      if (w[i]) r = {1'b1, STRIDE'(i)};
    return r;
  endfunction

  assign cmd_ready = (state == S_IDLE);
  assign is_ins    = (op_q == 2'b01);
  assign is_del    = (op_q == 2'b10);
  assign cmd_wr    = (cmd_op == 2'b01) ||
                     (cmd_op == 2'b10);

  // Search window, hit selection and read-modify-write word.
  always_comb begin
    exact = (pfx_q == tag_q[TAG_W-1:STRIDE]);
    lim   = exact ? tag_q[STRIDE-1:0] : '1;
    for (int i = 0; i < NODE_W; i++)
      mask[i] = (STRIDE'(i) <= lim);
    hit      = top_bit(rd_data & mask);
    bhit     = top_bit(rd_data);
    onehot   = NODE_W'(1) << tag_q[STRIDE-1:0];
    cur_bit  = |(rd_data & onehot);
    new_word = is_ins ? (rd_data | onehot)
                      : (rd_data & ~onehot);
  end

  // Next state, memory controls and result selection.
  always_comb begin
    state_n   = state;
    re        = 1'b0;
    raddr     = '0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    ld_cmd    = 1'b0;
    ld_word   = 1'b0;
    res_set   = 1'b0;
    res_tag   = '0;
    res_found = 1'b0;
    res_empty = 1'b0;
    unique case (state)
      S_INIT: begin
        we    = 1'b1;
        waddr = sweep;
        if (sweep == '1) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (cmd_valid) begin
          ld_cmd  = 1'b1;
          re      = 1'b1;
          raddr   = cmd_wr
                    ? incoming_tag_in[TAG_W-1:STRIDE]
                    : matching_prefix_in;
          state_n = S_RD;
        end
      end
      S_RD: state_n = S_EVAL;
      S_EVAL: begin
        if (is_ins || is_del) begin
          ld_word = 1'b1;
          state_n = S_WR;
        end else if (hit[STRIDE]) begin
          res_set   = 1'b1;
          res_tag   = {pfx_q, hit[STRIDE-1:0]};
          res_found = 1'b1;
          state_n   = S_IDLE;
        end else if (bakv_q) begin
          re      = 1'b1;
          raddr   = bak_q;
          state_n = S_BAK_RD;
        end else begin
          res_set = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_BAK_RD: state_n = S_BAK_EVAL;
      S_BAK_EVAL: begin
        res_set = 1'b1;
        if (bhit[STRIDE]) begin
          res_tag   = {bak_q, bhit[STRIDE-1:0]};
          res_found = 1'b1;
        end
        state_n = S_IDLE;
      end
      S_WR: begin
        we        = 1'b1;
        waddr     = tag_q[TAG_W-1:STRIDE];
        wdata     = word_q;
        res_set   = 1'b1;
        res_tag   = tag_q;
        res_found = old_q;
        res_empty = is_del && (word_q == '0);
        state_n   = S_IDLE;
      end
      default: state_n = S_INIT;
    endcase
  end

  // FSM state register and init sweep counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_INIT;
      sweep <= '0;
    end else if (ena) begin
      state <= state_n;
      if (state == S_INIT) sweep <= sweep + 1'b1;
    end
  end

  // Bitmap RAM: synchronous read and write, never reset.
  always_ff @(posedge clk) begin
    if (ena && re) rd_data <= mem[raddr];
    if (ena && we) mem[waddr] <= wdata;
  end

  // Command latch and pending read-modify-write word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q  <= '0;
      pfx_q  <= '0;
      bak_q  <= '0;
      bakv_q <= 1'b0;
      op_q   <= '0;
      old_q  <= 1'b0;
      word_q <= '0;
    end else if (ena) begin
      if (ld_cmd) begin
        tag_q  <= incoming_tag_in;
        pfx_q  <= matching_prefix_in;
        bak_q  <= bak_prefix_in;
        bakv_q <= bak_valid_in;
        op_q   <= cmd_op;
      end
      if (ld_word) begin
        old_q  <= cur_bit;
        word_q <= new_word;
      end
    end
  end

  // Result pulse; fields hold until the next result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_valid <= 1'b0;
      result_tag   <= '0;
      result_found <= 1'b0;
      node_empty   <= 1'b0;
    end else if (ena) begin
      result_valid <= res_set;
      if (res_set) begin
        result_tag   <= res_tag;
        result_found <= res_found;
        node_empty   <= res_empty;
      end
    end
  end

`ifdef STAGE3_OCCUPANCY_EN
  localparam logic [TAG_W:0] OCC_MAX = (TAG_W+1)'(1 << TAG_W);

  // Stored-tag count, saturating at both ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (ena) begin
      if (state == S_INIT) begin
        occupancy <= '0;
      end else if (state == S_WR) begin
        if (is_ins && !old_q && occupancy != OCC_MAX)
          occupancy <= occupancy + 1'b1;
        else if (is_del && old_q && occupancy != '0)
          occupancy <= occupancy - 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stage_3_leaf_search.sv
// Scoreboard bench for stage_3_leaf_search against a tag-set model.
// Define STAGE3_OCCUPANCY_EN to also check the occupancy count.
module tb_stage_3_leaf_search;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [11:0] incoming_tag_in = '0;
  logic [7:0]  matching_prefix_in = '0;
  logic [7:0]  bak_prefix_in = '0;
  logic        bak_valid_in = 1'b0;
  logic        result_valid;
  logic [11:0] result_tag;
  logic        result_found;
  logic        node_empty;
  logic [12:0] occupancy;

  stage_3_leaf_search dut (
    .clk                (clk),
    .rst                (rst),
    .ena                (ena),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_op             (cmd_op),
    .incoming_tag_in    (incoming_tag_in),
    .matching_prefix_in (matching_prefix_in),
    .bak_prefix_in      (bak_prefix_in),
    .bak_valid_in       (bak_valid_in),
    .result_valid       (result_valid),
    .result_tag         (result_tag),
    .result_found       (result_found),
    .node_empty         (node_empty)
`ifdef STAGE3_OCCUPANCY_EN
    ,
    .occupancy          (occupancy)
`endif
  );

`ifndef STAGE3_OCCUPANCY_EN
  assign occupancy = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] tag;
    logic        found;
    logic        empty;
    int          lat;
    int          occ;
  } exp_t;

  exp_t sb[$];
  bit   model_mem [4096];
  int   model_occ = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) model_mem[i] = 1'b0;
    model_occ = 0;
  endtask

  // Reference: the leaf store is a set of 12-bit tags.
  task automatic model_cmd(input logic [1:0] op,
                           input logic [11:0] tag,
                           input logic [7:0] pfx,
                           input logic [7:0] bak,
                           input logic bv,
                           output exp_t e);
    int  lim;
    bit  any;
    e.tag = '0; e.found = 1'b0; e.empty = 1'b0; e.lat = 2;
    if (op == 2'b01 || op == 2'b10) begin
      e.tag   = tag;
      e.found = model_mem[tag];
      e.lat   = 3;
      if (op == 2'b01 && !model_mem[tag]) model_occ++;
      if (op == 2'b10 && model_mem[tag]) model_occ--;
      model_mem[tag] = (op == 2'b01);
      if (op == 2'b10) begin
        any = 1'b0;
        for (int k = 0; k < 16; k++)
          if (model_mem[{tag[11:4], 4'(k)}]) any = 1'b1;
        e.empty = !any;
      end
    end else begin
      lim = (pfx == tag[11:4]) ? int'(tag[3:0]) : 15;
      for (int j = lim; j >= 0; j--)
        if (model_mem[{pfx, 4'(j)}]) begin
          e.found = 1'b1; e.tag = {pfx, 4'(j)};
          break;
        end
      if (!e.found && bv) begin
        e.lat = 4;
        for (int j = 15; j >= 0; j--)
          if (model_mem[{bak, 4'(j)}]) begin
            e.found = 1'b1; e.tag = {bak, 4'(j)};
            break;
          end
      end
    end
    e.occ = model_occ;
  endtask

  // Monitor: one check per consumed result pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst && ena && result_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result actual=%0h required=none",
                 result_tag);
      end else begin
        e = sb.pop_front();
        chk("result_tag", int'(result_tag), int'(e.tag));
        chk("result_found", int'(result_found), int'(e.found));
        chk("node_empty", int'(node_empty), int'(e.empty));
        chk("latency", cyc - acc_cyc, e.lat);
`ifdef STAGE3_OCCUPANCY_EN
        chk("occupancy", int'(occupancy), e.occ);
`endif
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL result_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  // mode: 0 plain, 1 stall 5 cycles in BAK_RD, 2 reset in WR.
  task automatic do_cmd(input logic [1:0] op, input logic [11:0] tag,
                        input logic [7:0] pfx, input logic [7:0] bak,
                        input logic bv, input int mode);
    exp_t e;
    bit   got;
    #1;
    model_cmd(op, tag, pfx, bak, bv, e);
    if (mode == 1) e.lat += 5;
    sb.push_back(e);
    cmd_op = op; incoming_tag_in = tag;
    matching_prefix_in = pfx; bak_prefix_in = bak;
    bak_valid_in = bv; cmd_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=0 required=1");
      cmd_valid = 1'b0;
      sb.delete();
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    incoming_tag_in = 12'($urandom);
    matching_prefix_in = 8'($urandom);
    bak_prefix_in = 8'($urandom);
    bak_valid_in = 1'($urandom);
    cmd_op = 2'($urandom);
    if (mode == 1) begin
      repeat (2) @(posedge clk);
      #1 ena = 1'b0;
      repeat (5) @(posedge clk);
      #1 ena = 1'b1;
    end else if (mode == 2) begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      model_clear();
      return;
    end
    wait_done();
  endtask

  // Reset, check idle outputs, time INIT, then a lookup of an empty tree.
  task automatic init_seq();
    exp_t e;
    int   n;
    rst = 1'b0;
    model_clear();
    cmd_op = 2'b00; incoming_tag_in = 12'h123;
    matching_prefix_in = 8'h12; bak_prefix_in = 8'h0A;
    bak_valid_in = 1'b0; cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result_tag", int'(result_tag), 0);
    chk("rst_result_found", int'(result_found), 0);
    chk("rst_node_empty", int'(node_empty), 0);
`ifdef STAGE3_OCCUPANCY_EN
    chk("rst_occupancy", int'(occupancy), 0);
`endif
    model_cmd(2'b00, 12'h123, 8'h12, 8'h0A, 1'b0, e);
    sb.push_back(e);
    acc_cyc = -1000;
    @(posedge clk); #1 rst = 1'b1;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
    end
    chk("init_len", n, 256);
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    logic [1:0]  op;
    logic [11:0] t;
    logic [7:0]  p, b;
    init_seq();
    do_cmd(2'b01, 12'h125, 8'h00, 8'h00, 1'b0, 0);
    do_cmd(2'b00, 12'h127, 8'h12, 8'h00, 1'b0, 0);
    do_cmd(2'b01, 12'h0A3, 8'h00, 8'h00, 1'b0, 0);
    do_cmd(2'b01, 12'h0A9, 8'h00, 8'h00, 1'b0, 0);
    do_cmd(2'b00, 12'h123, 8'h12, 8'h0A, 1'b1, 0);
    do_cmd(2'b00, 12'h123, 8'h12, 8'h0A, 1'b1, 1);
    do_cmd(2'b00, 12'h123, 8'h12, 8'h33, 1'b1, 0);
    do_cmd(2'b01, 12'h1F2, 8'h00, 8'h00, 1'b0, 0);
    do_cmd(2'b01, 12'h1FE, 8'h00, 8'h00, 1'b0, 0);
    do_cmd(2'b00, 12'h250, 8'h1F, 8'h00, 1'b0, 0);
    do_cmd(2'b11, 12'h1F5, 8'h1F, 8'h00, 1'b0, 0);
    do_cmd(2'b01, 12'h125, 8'h00, 8'h00, 1'b0, 0);
    do_cmd(2'b10, 12'h125, 8'h00, 8'h00, 1'b0, 0);
    do_cmd(2'b10, 12'h125, 8'h00, 8'h00, 1'b0, 0);
    do_cmd(2'b10, 12'h1F2, 8'h00, 8'h00, 1'b0, 0);
    do_cmd(2'b00, 12'h1F0, 8'h1F, 8'h0A, 1'b1, 0);
    for (int n = 0; n < 160; n++) begin
      op = 2'($urandom_range(0, 3));
      t  = {8'h10 + 8'($urandom_range(0, 3)), 4'($urandom)};
      p  = ($urandom_range(0, 1) == 1) ? t[11:4]
           : 8'h10 + 8'($urandom_range(0, 3));
      b  = 8'h0E + 8'($urandom_range(0, 5));
      do_cmd(op, t, p, b, 1'($urandom), 0);
    end
    do_cmd(2'b01, 12'h3C5, 8'h00, 8'h00, 1'b0, 2);
    repeat (3) @(posedge clk);
    init_seq();
    do_cmd(2'b00, 12'h0AF, 8'h0A, 8'h12, 1'b1, 0);
    do_cmd(2'b01, 12'h3C5, 8'h00, 8'h00, 1'b0, 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
